wb_queue: RTL
=============

// Module: wb_queue
// PURPOSE
//  Writeback queue: the producer end of the register-file write port (wen/waddr/wdata).
//  Accepts results from the execute/memory stages over a valid/ready handshake, buffers them in order,
//  drains at most one entry per cycle into regfile. Lookup ports let decode see values still queued.
// PARAMETERS
//  XLEN   32  data width of a register value
//  AW     5   register address width (32 architectural registers)
//  DEPTH  4   queue entries; power of two, >= 2
// PORTS
//  clk        in   1                 clock; all state updates on rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   1                 producer offers a result
//  in_ready   out  1                 queue can accept this cycle
//  in_rd      in   AW                destination register
//  in_data    in   XLEN              result value
//  rf_hold    in   1                 1 = regfile port unavailable, do not drain this cycle
//  wen        out  1                 regfile write enable
//  waddr      out  AW                regfile write address
//  wdata      out  XLEN              regfile write data
//  lk_addr1   in   AW                lookup address, port 1
//  lk_hit1    out  1                 port 1 found a queued write
//  lk_data1   out  XLEN              port 1 value (youngest match)
//  lk_addr2   in   AW                lookup address, port 2
//  lk_hit2    out  1                 port 2 found a queued write
//  lk_data2   out  XLEN              port 2 value (youngest match)
//  count      out  $clog2(DEPTH)+1   occupied entries
// BEHAVIOUR
//  - Circular buffer: head/tail pointers plus count; pointers wrap modulo DEPTH.
//  - in_ready = (count < DEPTH); combinational from state only, never from in_valid or rf_hold.
//  - Accept (in_valid && in_ready) at edge N: entry enters at tail; visible at head from cycle N+1 if queue was empty.
//  - in_rd == 0: handshake completes (accepted) but nothing is enqueued; count unchanged.
//  - wen = (count != 0) && !rf_hold; waddr/wdata = head entry; combinational from state and rf_hold.
//  - Drain: when wen=1 the head is popped at the same edge the regfile captures it. Min accept->write: 1 cycle.
//  - When count==0: wen=0, waddr=0, wdata=0 (driven zero, not don't-care).
//  - Simultaneous accept and drain: both happen; count unchanged. At count==DEPTH, in_ready=0 even if
//    a drain occurs that cycle (no same-cycle pass-through).
//  - Order preserved: same-register writes reach regfile in acceptance order.
//  - Lookup: compares lk_addrN against all valid entries (head included); youngest match wins;
//    lk_addrN==0 -> hit=0, data=0; no match -> hit=0, data=0. Purely combinational.
//  - Reset (including mid-operation): count=0, head=tail=0, in_ready=1 from the next cycle, wen=0, all
//    lk_hit=0; queued entries discarded, no partial write emitted. Stored data need not be cleared.
//  - No state machine beyond the pointer/count datapath; count never exceeds DEPTH nor underflows.
// CONFIGURATION
//  WB_QUEUE_BYPASS_EN defined: lookup ports function as above.
//  Not defined: lk_hit1/lk_hit2 tied 0, lk_data1/lk_data2 tied 0, comparators removed; decode must stall
//  until count==0 for correctness. Queue/drain behaviour identical in both builds.
// TESTING
//  1 Reset: rst=1 two cycles -> count=0, in_ready=1, wen=0, lk_hit1=lk_hit2=0.
//  2 Single write: accept rd=1 data=32'hdeadbeef, rf_hold=0 -> next cycle wen=1 waddr=1 wdata=32'hdeadbeef, then count=0.
//  3 Fill/hold: rf_hold=1, accept rd=1,2,3,4 (32'hb105f00d,32'h8badf00d,32'hbaadcafe,32'hcafed00d)
//    -> count=4, in_ready=0; release rf_hold -> four writes in that order on consecutive cycles.
//  4 Bypass (WB_QUEUE_BYPASS_EN): rf_hold=1, accept rd=5 32'h11111111 then rd=5 32'h22222222; lk_addr1=5
//    -> lk_hit1=1 lk_data1=32'h22222222; lk_addr2=0 -> lk_hit2=0. Without macro: lk_hit1=0.
//  5 x0 drop + concurrency: accept rd=0 32'hffffffff -> count stays 0, no wen; at count=2 accept while
//    draining -> count stays 2, pointers wrap past DEPTH correctly.
//  6 Reset mid-operation: count=3, assert rst one cycle -> count=0, wen=0 next cycle; no stale entry written.

Source files
------------

// File: rtl/wb_queue.sv
// Writeback queue: buffers execute/memory results in order and drains one per cycle into the regfile.
// Build option WB_QUEUE_BYPASS_EN enables the decode lookup ports; without it they are tied to zero.
module wb_queue #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     rf_hold,
  output logic                     wen,
  output logic [AW-1:0]            waddr,
  output logic [XLEN-1:0]          wdata,
  input  logic [AW-1:0]            lk_addr1,
  output logic                     lk_hit1,
  output logic [XLEN-1:0]          lk_data1,
  input  logic [AW-1:0]            lk_addr2,
  output logic                     lk_hit2,
  output logic [XLEN-1:0]          lk_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   head, tail;
  logic [AW-1:0]   rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic            push, pop;

  assign in_ready = (count < CW'(DEPTH));
  // Writes to x0 complete the handshake but are never stored.
  assign push     = in_valid && in_ready && (in_rd != '0);
  assign wen      = (count != '0) && !rf_hold;
  assign pop      = wen;
  assign waddr    = (count != '0) ? rd_mem[head]   : '0;
  assign wdata    = (count != '0) ? data_mem[head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= in_rd;
      data_mem[tail] <= in_data;
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  // Walk oldest to youngest so the youngest match is the one that sticks.
  function automatic logic [XLEN:0] lookup(input logic [AW-1:0] a);
    logic [XLEN:0] r;
    logic [PW-1:0] idx;
    r = '0;
    if (a != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (rd_mem[idx] == a)) r = {1'b1, data_mem[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {lk_hit1, lk_data1} = lookup(lk_addr1);
    {lk_hit2, lk_data2} = lookup(lk_addr2);
  end
`else
  logic unused_lk;
  assign unused_lk = ^{lk_addr1, lk_addr2};
  assign lk_hit1   = 1'b0;
  assign lk_data1  = '0;
  assign lk_hit2   = 1'b0;
  assign lk_data2  = '0;
`endif

endmodule
